// File: rtl/mem_lsu_ysyx_23060136.sv
// MEM-stage load/store unit: one instruction in flight, one valid/ready bus transaction per
// memory op, store byte-lane steering and load alignment/extension toward write-back.
module mem_lsu_ysyx_23060136 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_i_valid,
    output logic                  MEM_o_ready,
    input  logic [ADDR_W-1:0]     MEM_i_addr,
    input  logic [DATA_W-1:0]     MEM_i_wdata,
    input  logic                  MEM_i_write_mem,
    input  logic                  MEM_i_mem_to_reg,
    input  logic                  MEM_i_mem_byte,
    input  logic                  MEM_i_mem_half,
    input  logic                  MEM_i_mem_word,
    input  logic                  MEM_i_mem_byte_u,
    input  logic                  MEM_i_mem_half_u,
    output logic                  MEM_o_valid,
    input  logic                  MEM_i_ready,
    output logic [DATA_W-1:0]     MEM_o_rdata,
    output logic                  MEM_o_misalign,
    output logic                  LSU_o_req_valid,
    input  logic                  LSU_i_req_ready,
    output logic [ADDR_W-1:0]     LSU_o_addr,
    output logic                  LSU_o_wen,
    output logic [DATA_W-1:0]     LSU_o_wdata,
    output logic [DATA_W/8-1:0]   LSU_o_wstrb,
    input  logic                  LSU_i_resp_valid,
    input  logic [DATA_W-1:0]     LSU_i_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [1:0]        size_p0;
    logic              uns_p0;
    logic              wen_p0;
    logic              load_p0;
    logic [DATA_W-1:0] rdata_p1;
    logic              misalign_p1;

    logic              is_byte;
    logic              is_half;
    logic              word_sel;
    logic [1:0]        size_in;
    logic              is_mem;
    logic              misalign_in;
    logic              accept;

    function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] word,
                                                   input logic [1:0] off,
                                                   input logic [1:0] size,
                                                   input logic uns);
        logic [DATA_W-1:0]        s;
        logic signed [7:0]        b;
        logic signed [15:0]       h;
        logic signed [DATA_W-1:0] ext;
        s = word >> {off, 3'b000};
        b = s[7:0];
        h = s[15:0];
        ext = '0;
        case (size)
            SZ_B:    ext = uns ? $signed({{(DATA_W-8){1'b0}}, s[7:0]}) : b;
            SZ_H:    ext = uns ? $signed({{(DATA_W-16){1'b0}}, s[15:0]}) : h;
            default: ext = $signed(s);
        endcase
        return ext;
    endfunction

    function automatic logic [DATA_W/8-1:0] steer_wstrb(input logic [1:0] size,
                                                        input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] steer_wdata(input logic [1:0] size,
                                                      input logic [DATA_W-1:0] data);
        case (size)
            SZ_B:    return {4{data[7:0]}};
            SZ_H:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    // Flags are one-hot; anything that is neither byte nor half is a word access.
    assign is_byte     = MEM_i_mem_byte | MEM_i_mem_byte_u;
    assign is_half     = MEM_i_mem_half | MEM_i_mem_half_u;
    assign word_sel    = MEM_i_mem_word | ~(is_byte | is_half);
    assign size_in     = (word_sel & ~is_byte & ~is_half) ? SZ_W : (is_byte ? SZ_B : SZ_H);
    assign is_mem      = MEM_i_write_mem | MEM_i_mem_to_reg;
    assign misalign_in = ((size_in == SZ_H) & MEM_i_addr[0]) |
                         ((size_in == SZ_W) & (MEM_i_addr[1:0] != 2'b00));

    assign MEM_o_ready = rst & ((state == IDLE) | ((state == DONE) & MEM_i_ready));
    assign accept      = MEM_i_valid & MEM_o_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            addr_p0     <= '0;
            wdata_p0    <= '0;
            size_p0     <= SZ_B;
            uns_p0      <= 1'b0;
            wen_p0      <= 1'b0;
            load_p0     <= 1'b0;
            rdata_p1    <= '0;
            misalign_p1 <= 1'b0;
        end else if (accept) begin
            // stage p0: capture the instruction; write_mem has priority over mem_to_reg
            addr_p0     <= MEM_i_addr;
            wdata_p0    <= MEM_i_wdata;
            size_p0     <= size_in;
            uns_p0      <= MEM_i_mem_byte_u | MEM_i_mem_half_u;
            wen_p0      <= MEM_i_write_mem;
            load_p0     <= MEM_i_mem_to_reg & ~MEM_i_write_mem;
            rdata_p1    <= '0;
            misalign_p1 <= is_mem & misalign_in;
            state       <= (is_mem & ~misalign_in) ? REQ : DONE;
        end else begin
            case (state)
                REQ:  if (LSU_i_req_ready) state <= WAIT;
                WAIT: if (LSU_i_resp_valid) begin
                    // stage p1: formatted result held for write-back
                    rdata_p1 <= load_p0 ? fmt_load(LSU_i_rdata, addr_p0[1:0], size_p0, uns_p0)
                                        : '0;
                    state    <= DONE;
                end
                DONE: if (MEM_i_ready) state <= IDLE;
                default: ;
            endcase
        end
    end

    assign MEM_o_valid     = (state == DONE);
    assign MEM_o_rdata     = rdata_p1;
    assign MEM_o_misalign  = misalign_p1;
    assign LSU_o_req_valid = (state == REQ);
    assign LSU_o_addr      = {addr_p0[ADDR_W-1:2], 2'b00};
    assign LSU_o_wen       = wen_p0;
    assign LSU_o_wdata     = steer_wdata(size_p0, wdata_p0);
    assign LSU_o_wstrb     = wen_p0 ? steer_wstrb(size_p0, addr_p0[1:0]) : '0;

endmodule

// File: tb/tb_mem_lsu_ysyx_23060136.sv
// Directed bench for the MEM-stage LSU: a scoreboard of expected results and bus requests,
// a programmable bus responder, and literal checks on the documented scenarios.
module tb_mem_lsu_ysyx_23060136;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_i_valid, MEM_o_ready;
    logic [31:0] MEM_i_addr, MEM_i_wdata;
    logic        MEM_i_write_mem, MEM_i_mem_to_reg;
    logic        MEM_i_mem_byte, MEM_i_mem_half, MEM_i_mem_word, MEM_i_mem_byte_u, MEM_i_mem_half_u;
    logic        MEM_o_valid, MEM_i_ready;
    logic [31:0] MEM_o_rdata;
    logic        MEM_o_misalign;
    logic        LSU_o_req_valid, LSU_i_req_ready;
    logic [31:0] LSU_o_addr;
    logic        LSU_o_wen;
    logic [31:0] LSU_o_wdata;
    logic [3:0]  LSU_o_wstrb;
    logic        LSU_i_resp_valid;
    logic [31:0] LSU_i_rdata;

    always #5 clk = ~clk;

    mem_lsu_ysyx_23060136 dut (
        .clk(clk), .rst(rst),
        .MEM_i_valid(MEM_i_valid), .MEM_o_ready(MEM_o_ready),
        .MEM_i_addr(MEM_i_addr), .MEM_i_wdata(MEM_i_wdata),
        .MEM_i_write_mem(MEM_i_write_mem), .MEM_i_mem_to_reg(MEM_i_mem_to_reg),
        .MEM_i_mem_byte(MEM_i_mem_byte), .MEM_i_mem_half(MEM_i_mem_half),
        .MEM_i_mem_word(MEM_i_mem_word), .MEM_i_mem_byte_u(MEM_i_mem_byte_u),
        .MEM_i_mem_half_u(MEM_i_mem_half_u),
        .MEM_o_valid(MEM_o_valid), .MEM_i_ready(MEM_i_ready),
        .MEM_o_rdata(MEM_o_rdata), .MEM_o_misalign(MEM_o_misalign),
        .LSU_o_req_valid(LSU_o_req_valid), .LSU_i_req_ready(LSU_i_req_ready),
        .LSU_o_addr(LSU_o_addr), .LSU_o_wen(LSU_o_wen),
        .LSU_o_wdata(LSU_o_wdata), .LSU_o_wstrb(LSU_o_wstrb),
        .LSU_i_resp_valid(LSU_i_resp_valid), .LSU_i_rdata(LSU_i_rdata)
    );

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
    } res_t;
    res_t exp_q[$];

    logic        bus_exp = 1'b0;
    logic [31:0] eb_addr, eb_wdata;
    logic [3:0]  eb_wstrb;
    logic        eb_wen;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_wstrb;
    logic        snap_wen;
    int          n_stall = 0;
    int          n_valid = 0;

    logic [31:0] bus_rdata = 32'h0;
    int          rr_wait = 0;
    int          resp_wait = 0;
    logic        force_resp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail(input string name, input string what);
        total++;
        $display("FAIL %s: %s", name, what);
    endtask

    // sz: 0=byte 1=half 2=word 3=byte_u 4=half_u
    function automatic bit model_mis(input logic [31:0] a, input int sz);
        if (sz == 1 || sz == 4) return (a % 2) != 0;
        if (sz == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] o, input int sz);
        logic [31:0] s;
        int v;
        s = w >> (8 * o);
        case (sz)
            0: begin v = $signed(s[7:0]);  return v; end
            1: begin v = $signed(s[15:0]); return v; end
            3: return s & 32'hFF;
            4: return s & 32'hFFFF;
            default: return s;
        endcase
    endfunction

    function automatic int model_bytes(input int sz);
        if (sz == 0 || sz == 3) return 1;
        if (sz == 1 || sz == 4) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int sz);
        if (model_bytes(sz) == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (model_bytes(sz) == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [31:0] a, input int sz);
        int n;
        n = ((1 << model_bytes(sz)) - 1) << (a % 4);
        return n[3:0];
    endfunction

    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input bit wr,
                         input bit ld, input int sz, output int waits);
        bit   accepted;
        bit   mem;
        bit   mis;
        res_t r;
        MEM_i_addr = addr;
        MEM_i_wdata = wdata;
        MEM_i_write_mem = wr;
        MEM_i_mem_to_reg = ld;
        MEM_i_mem_byte = (sz == 0);
        MEM_i_mem_half = (sz == 1);
        MEM_i_mem_word = (sz == 2);
        MEM_i_mem_byte_u = (sz == 3);
        MEM_i_mem_half_u = (sz == 4);
        MEM_i_valid = 1'b1;
        waits = 0;
        accepted = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            waits++;
            if (MEM_o_ready) begin
                accepted = 1;
                break;
            end
        end
        if (!accepted) fail("accept_timeout", "ready never seen, required within 50 cycles");
        else begin
            mem = wr || ld;
            mis = mem && model_mis(addr, sz);
            r.mis = mis;
            r.rdata = (ld && !wr && !mis) ? model_load(bus_rdata, addr[1:0], sz) : 32'h0;
            exp_q.push_back(r);
            if (mem && !mis) begin
                bus_exp = 1'b1;
                eb_addr = addr & ~32'h3;
                eb_wen = wr;
                eb_wstrb = wr ? model_wstrb(addr, sz) : 4'h0;
                eb_wdata = model_wdata(wdata, sz);
            end
        end
        @(posedge clk); #1;
        MEM_i_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output logic [31:0] rd, output logic mis);
        lat = 0;
        rd = 32'h0;
        mis = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (MEM_o_valid) begin
                lat = k;
                rd = MEM_o_rdata;
                mis = MEM_o_misalign;
                break;
            end
        end
        if (lat == 0) fail("result_timeout", "MEM_o_valid never seen, required within 60 cycles");
        @(posedge clk); #1;
    endtask

    // Scoreboard: every meaningful cycle the bus request and the write-back result are checked.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (LSU_o_req_valid) begin
                    if (!bus_exp) fail("unexpected_req", "req_valid=1, required 0");
                    else begin
                        check("req_addr", LSU_o_addr, eb_addr);
                        check("req_wen", {31'h0, LSU_o_wen}, {31'h0, eb_wen});
                        check("req_wstrb", {28'h0, LSU_o_wstrb}, {28'h0, eb_wstrb});
                        if (eb_wen) check("req_wdata", LSU_o_wdata, eb_wdata);
                    end
                    if (LSU_i_req_ready) begin
                        bus_exp = 1'b0;
                        snap_addr = LSU_o_addr;
                        snap_wdata = LSU_o_wdata;
                        snap_wstrb = LSU_o_wstrb;
                        snap_wen = LSU_o_wen;
                    end else n_stall++;
                end
                if (MEM_o_valid) begin
                    n_valid++;
                    if (exp_q.size() == 0) fail("spurious_valid", "MEM_o_valid=1, required 0");
                    else begin
                        check("wb_rdata", MEM_o_rdata, exp_q[0].rdata);
                        check("wb_misalign", {31'h0, MEM_o_misalign}, {31'h0, exp_q[0].mis});
                        if (MEM_i_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Bus responder: req_ready after rr_wait stall cycles, response resp_wait cycles later.
    initial begin
        int  phase;
        int  cnt;
        bit  rv;
        phase = 0;
        cnt = 0;
        LSU_i_req_ready = 1'b0;
        LSU_i_resp_valid = 1'b0;
        LSU_i_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            rv = 0;
            if (phase == 4) begin
                phase = 0;
            end else if (phase == 2) begin
                LSU_i_req_ready = 1'b0;
                cnt = 0;
                phase = 3;
            end
            if (phase == 0 && LSU_o_req_valid) begin
                phase = 1;
                cnt = 0;
            end
            if (phase == 1) begin
                if (cnt == rr_wait) begin
                    LSU_i_req_ready = 1'b1;
                    phase = 2;
                end else begin
                    LSU_i_req_ready = 1'b0;
                    cnt++;
                end
            end else if (phase == 3) begin
                if (cnt == resp_wait) begin
                    rv = 1;
                    LSU_i_rdata = bus_rdata;
                    phase = 4;
                end else cnt++;
            end
            LSU_i_resp_valid = rv | force_resp;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, lat, n0;
        logic [31:0] rd;
        logic        mis;
        bit          hs;

        rst = 1'b0;
        MEM_i_valid = 1'b1;
        MEM_i_addr = 32'h0;
        MEM_i_wdata = 32'h0;
        MEM_i_write_mem = 1'b0;
        MEM_i_mem_to_reg = 1'b1;
        MEM_i_mem_byte = 1'b0;
        MEM_i_mem_half = 1'b0;
        MEM_i_mem_word = 1'b1;
        MEM_i_mem_byte_u = 1'b0;
        MEM_i_mem_half_u = 1'b0;
        MEM_i_ready = 1'b1;
        force_resp = 1'b1;

        // Reset held with valid and a stray response present
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", {31'h0, MEM_o_ready}, 32'h0);
            check("rst_req_valid", {31'h0, LSU_o_req_valid}, 32'h0);
            check("rst_valid", {31'h0, MEM_o_valid}, 32'h0);
            check("rst_rdata", MEM_o_rdata, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        MEM_i_valid = 1'b0;
        force_resp = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'h0, MEM_o_ready}, 32'h1);
        @(posedge clk); #1;

        // lb / lbu at offset 3
        bus_rdata = 32'h80FF_1234;
        issue(32'h8000_0003, 32'h0, 0, 1, 0, w);
        wait_result(lat, rd, mis);
        check("lb_latency", lat, 3);
        check("lb_rdata", rd, 32'hFFFF_FF80);
        check("lb_addr", snap_addr, 32'h8000_0000);
        check("lb_wstrb", {28'h0, snap_wstrb}, 32'h0);
        check("lb_wen", {31'h0, snap_wen}, 32'h0);
        issue(32'h8000_0003, 32'h0, 0, 1, 3, w);
        wait_result(lat, rd, mis);
        check("lbu_rdata", rd, 32'h0000_0080);

        // sh at two lane positions, second with a stalled bus
        issue(32'h100, 32'hDEAD_BEEF, 1, 0, 1, w);
        wait_result(lat, rd, mis);
        check("sh0_wstrb", {28'h0, snap_wstrb}, 32'h3);
        check("sh0_wdata", snap_wdata, 32'hBEEF_BEEF);
        check("sh0_rdata", rd, 32'h0);
        rr_wait = 4;
        n_stall = 0;
        issue(32'h102, 32'hDEAD_BEEF, 1, 0, 1, w);
        wait_result(lat, rd, mis);
        check("sh2_wstrb", {28'h0, snap_wstrb}, 32'hC);
        check("sh2_wdata", snap_wdata, 32'hBEEF_BEEF);
        check("sh2_stall_cycles", n_stall, 4);
        check("sh2_latency", lat, 7);
        rr_wait = 0;

        // Misalignment rules
        issue(32'h101, 32'h0, 0, 1, 2, w);
        wait_result(lat, rd, mis);
        check("lw_mis_latency", lat, 1);
        check("lw_mis_flag", {31'h0, mis}, 32'h1);
        check("lw_mis_rdata", rd, 32'h0);
        issue(32'h101, 32'h0, 0, 1, 1, w);
        wait_result(lat, rd, mis);
        check("lh_mis_flag", {31'h0, mis}, 32'h1);
        issue(32'h101, 32'h0, 0, 1, 0, w);
        wait_result(lat, rd, mis);
        check("lb_odd_flag", {31'h0, mis}, 32'h0);
        check("lb_odd_rdata", rd, 32'h0000_0012);
        check("lb_odd_latency", lat, 3);

        // Back-to-back ALU pass-through
        n0 = n_valid;
        for (int i = 0; i < 4; i++) begin
            issue(32'h40 + i * 5, $urandom, 0, 0, 2, w);
            check("alu_accept_wait", w, 1);
        end
        wait_result(lat, rd, mis);
        check("alu_last_rdata", rd, 32'h0);
        check("alu_valid_cycles", n_valid - n0, 4);

        // Write-back stall holds the result and blocks upstream
        issue(32'h77, 32'h1111_2222, 0, 0, 2, w);
        MEM_i_ready = 1'b0;
        fork
            issue(32'h88, 32'h3333_4444, 0, 0, 2, w);
            begin
                repeat (2) begin
                    @(negedge clk);
                    check("hold_valid", {31'h0, MEM_o_valid}, 32'h1);
                    check("hold_ready", {31'h0, MEM_o_ready}, 32'h0);
                    check("hold_rdata", MEM_o_rdata, 32'h0);
                end
                @(posedge clk); #1;
                MEM_i_ready = 1'b1;
            end
        join
        check("hold_accept_wait", w, 3);
        wait_result(lat, rd, mis);
        check("hold_next_latency", lat, 1);

        // Reset while waiting for the response; the late response must be ignored
        bus_rdata = 32'h1234_5678;
        resp_wait = 6;
        issue(32'h200, 32'h0, 0, 1, 2, w);
        hs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (LSU_o_req_valid && LSU_i_req_ready) begin
                hs = 1;
                break;
            end
        end
        check("rstwait_handshake", {31'h0, hs}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        bus_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        n0 = n_valid;
        repeat (10) @(posedge clk);
        #1;
        check("rstwait_no_valid", n_valid - n0, 0);
        resp_wait = 0;
        issue(32'h200, 32'h0, 0, 1, 2, w);
        wait_result(lat, rd, mis);
        check("lw_after_rst_rdata", rd, 32'h1234_5678);
        check("lw_after_rst_latency", lat, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
